// File: rtl/shift_add_multiplier.sv
// Sequential 32x32->64 shift-add multiplier with start/busy/done handshake, built around a CLA Adder.
// Define SIGNED_MUL_EN for two's-complement operands (adds a 2-cycle FIX state, 35-edge latency).

module Adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);
  logic [8:0] blk_c;

  assign blk_c[0] = c_in;

  // Eight 4-bit lookahead blocks, carries rippled between blocks.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_cla
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      assign g    = a[gi*4 +: 4] & b[gi*4 +: 4];
      assign p    = a[gi*4 +: 4] ^ b[gi*4 +: 4];
      assign c[0] = blk_c[gi];
      assign c[1] = g[0] | (p[0] & c[0]);
      assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c[0]);
      assign sum[gi*4 +: 4] = p ^ c[3:0];
      assign blk_c[gi+1]    = c[4];
    end
  endgenerate

  assign c_out = blk_c[8];
endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
`ifdef SIGNED_MUL_EN
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   acc_hi_q;
  logic [WIDTH-1:0]   acc_lo_q;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
`ifdef SIGNED_MUL_EN
  logic               sign_q;
  logic               fix_c_q;

  // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
  assign mag_a = op_a[WIDTH-1] ? (~op_a + WIDTH'(1)) : op_a;
  assign mag_b = op_b[WIDTH-1] ? (~op_b + WIDTH'(1)) : op_b;
`else
  assign mag_a = op_a;
  assign mag_b = op_b;
`endif

  always_comb begin
    add_a   = acc_hi_q;
    add_b   = acc_lo_q[0] ? mcand_q : '0;
    add_cin = 1'b0;
`ifdef SIGNED_MUL_EN
    // FIX reuses the adder for ~x + carry on the low word, then the high word.
    if (state_q == FIX) begin
      add_b = '0;
      if (!count_q[0]) begin
        add_a   = ~acc_lo_q;
        add_cin = 1'b1;
      end else begin
        add_a   = ~acc_hi_q;
        add_cin = fix_c_q;
      end
    end
`endif
  end

  Adder u_adder (
    .a     (add_a),
    .b     (add_b),
    .c_in  (add_cin),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
`ifdef SIGNED_MUL_EN
      sign_q   <= 1'b0;
      fix_c_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= mag_a;
            acc_hi_q <= '0;
            acc_lo_q <= mag_b;
            count_q  <= '0;
            busy     <= 1'b1;
            state_q  <= CALC;
`ifdef SIGNED_MUL_EN
            sign_q   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
`endif
          end
        end
        CALC: begin
          // 65-bit right shift: carry-out lands in bit 63.
          {acc_hi_q, acc_lo_q} <= {add_cout, add_sum, acc_lo_q[WIDTH-1:1]};
          count_q <= count_q + CNT_W'(1);
          if (count_q == LAST_ITER) begin
`ifdef SIGNED_MUL_EN
            state_q <= FIX;
`else
            state_q <= DONE;
`endif
          end
        end
`ifdef SIGNED_MUL_EN
        FIX: begin
          count_q <= count_q + CNT_W'(1);
          if (sign_q) begin
            if (!count_q[0]) begin
              acc_lo_q <= add_sum;
              fix_c_q  <= add_cout;
            end else begin
              acc_hi_q <= add_sum;
            end
          end
          if (count_q[0]) state_q <= DONE;
        end
`endif
        DONE: begin
          product <= {acc_hi_q, acc_lo_q};
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: vector table, hand-written corner sequences, random ops vs a plain-arithmetic model.
`timescale 1ns/1ps
module tb_shift_add_multiplier;
`ifdef SIGNED_MUL_EN
  localparam int LAT = 35;
`else
  localparam int LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_prod = '0;

  always #5 clk = ~clk;

  shift_add_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    bit          spam;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
`ifdef SIGNED_MUL_EN
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    return 64'(sa * sb);
`else
    return {32'b0, a} * {32'b0, b};
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Issue one operation and follow it to its done pulse.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                        input bit spam, input string name);
    int cyc;
    int dones;
    bit busy_ok;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = spam;
    op_a  = $urandom;
    op_b  = $urandom;
    chk({name, " busy_after_start"}, 64'(busy), 64'd1);
    chk({name, " product_held"}, product, last_prod);
    cyc = 0;
    dones = 0;
    busy_ok = 1'b1;
    while (!done && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      if (spam && !done) start = 1'(($urandom_range(0, 3) != 0) ? 1 : 0);
      op_a = $urandom;
      op_b = $urandom;
    end
    start = 1'b0;
    if (done) dones++;
    chk({name, " busy_held"}, 64'(busy_ok), 64'd1);
    chk({name, " latency"}, 64'(cyc), 64'(LAT));
    chk({name, " busy_with_done"}, 64'(busy), 64'd0);
    chk({name, " product"}, product, exp);
    @(posedge clk);
    #1;
    if (done) dones++;
    chk({name, " single_done"}, 64'(dones), 64'd1);
    chk({name, " idle_after"}, 64'(busy), 64'd0);
    last_prod = exp;
    $display("op %s: 0x%h * 0x%h -> 0x%h (expected 0x%h, %0d cycles)", name, a, b, product, exp, cyc);
  endtask

  initial begin
`ifdef SIGNED_MUL_EN
    vecs[0] = '{32'd7,        32'd6,        64'h000000000000002A, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 1'b0};
    vecs[2] = '{32'h12345678, 32'd0,        64'h0000000000000000, 1'b1};
    vecs[3] = '{32'hFFFFFFFD, 32'd5,        64'hFFFFFFFFFFFFFFF1, 1'b0};
    vecs[4] = '{32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0};
    vecs[5] = '{32'd0,        32'hFFFFFFFF, 64'h0000000000000000, 1'b0};
`else
    vecs[0] = '{32'd7,        32'd6,        64'h000000000000002A, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0};
    vecs[2] = '{32'h12345678, 32'd0,        64'h0000000000000000, 1'b1};
    vecs[3] = '{32'hFFFFFFFD, 32'd5,        64'h00000004FFFFFFF1, 1'b0};
    vecs[4] = '{32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0};
    vecs[5] = '{32'd0,        32'hFFFFFFFF, 64'h0000000000000000, 1'b0};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset product", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].spam, $sformatf("vec%0d", i));

    // Reset in the middle of a 3*5 operation.
    begin
      bit no_done;
      @(negedge clk);
      op_a = 32'd3;
      op_b = 32'd5;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      no_done = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk);
        #1;
        if (done) no_done = 1'b0;
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst busy", 64'(busy), 64'd0);
      chk("midrst product", product, 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk);
        #1;
        if (done || busy) no_done = 1'b0;
      end
      chk("midrst no_done", 64'(no_done), 64'd1);
      $display("op midrst: reset during 3*5, busy=%0d product=0x%h", busy, product);
      last_prod = '0;
      run_op(32'd3, 32'd5, 64'd15, 1'b0, "after_rst");
    end

    // Back-to-back with start held high: 2*3 then 4*5.
    begin
      int cyc;
      int gap;
      bit stable;
      @(negedge clk);
      op_a = 32'd2;
      op_b = 32'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      op_a = 32'd4;
      op_b = 32'd5;
      cyc = 0;
      while (!done && cyc < 100) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      chk("b2b first latency", 64'(cyc), 64'(LAT));
      chk("b2b first product", product, 64'd6);
      $display("op b2b1: 2*3 -> 0x%h after %0d cycles", product, cyc);
      gap = 0;
      stable = 1'b1;
      do begin
        @(posedge clk);
        #1;
        gap++;
        if (!done && product !== 64'd6) stable = 1'b0;
      end while (!done && gap < 100);
      start = 1'b0;
      chk("b2b gap", 64'(gap), 64'(LAT + 1));
      chk("b2b stable", 64'(stable), 64'd1);
      chk("b2b second product", product, 64'd20);
      $display("op b2b2: 4*5 -> 0x%h, %0d cycles after first done", product, gap);
      last_prod = 64'd20;
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 12; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra[31] = 1'b1;
      if (i % 4 == 2) rb = 32'(rb >> $urandom_range(0, 31));
      run_op(ra, rb, ref_mul(ra, rb), 1'(i % 3 == 0), $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential 32x32 -> 64-bit multiplier for the RISC datapath's MUL path.
- Sits directly upstream of the 32-bit ripple-of-CLA `Adder`. It instantiates one `Adder` and feeds it the running partial product and the multiplicand every iteration, then consumes its sum and carry-out.
- Uses a start/busy/done handshake with the control unit.
- Result is held on `product` until the next accepted start.

Parameters:
- WIDTH, 32, operand width. Fixed at 32 to match the `Adder` instance; other values are unsupported.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk      input   1   system clock, rising-edge
- rst      input   1   asynchronous, active-high reset
- start    input   1   request; sampled only in IDLE
- op_a     input   32  multiplicand; sampled with start
- op_b     input   32  multiplier; sampled with start
- busy     output  1   high while an operation is in progress
- done     output  1   one-cycle completion pulse
- product  output  64  result; valid from the done cycle onward

Behaviour:
- Interface (already decided): one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values:
  - state=IDLE, count=0, busy=0, done=0, product=0.
  - Internal regs mcand=0, acc_hi=0, acc_lo=0.
- States: IDLE, CALC, DONE (plus FIX when SIGNED_MUL_EN is defined).
- IDLE:
  - On an edge with start=1: mcand<=op_a, acc_hi<=0, acc_lo<=op_b, count<=0, busy<=1, go to CALC.
  - start=0: remain in IDLE.
- CALC, one iteration per clock:
  - `Adder` inputs: a=acc_hi, b=(acc_lo[0] ? mcand : 0), c_in=0.
  - Update {acc_hi, acc_lo} <= {c_out, sum, acc_lo} >> 1, i.e. a 65-bit right shift with the adder carry-out entering bit 63.
  - count increments each iteration. After the iteration at count==31, go to DONE.
  - This gives exactly 32 CALC cycles.
- DONE:
  - product<={acc_hi, acc_lo}, done=1 for exactly one cycle, busy=0, then return to IDLE.
  - done and the new product appear together.
- Latency (unsigned): start sampled at edge E0 -> done high in the cycle following edge E33.
  - busy is high from after E0 until E33.
  - A new start is accepted at the earliest on the edge that ends the done cycle.
- start while busy or in DONE is ignored. op_a/op_b changes during busy have no effect.
- product is held stable from DONE until the next accepted start's DONE; it does not clear on start.
- Boundary cases:
  - op_a=0 or op_b=0 gives product 0 with full latency (no early termination).
  - 0xFFFFFFFF*0xFFFFFFFF relies on the carry-out path; the result must be 0xFFFFFFFE00000001.
- Reset mid-operation returns immediately to reset values. No done pulse is emitted and product clears to 0.
- done and busy are never high together.

Optional Feature:
- Macro: SIGNED_MUL_EN.
- When defined, operands are two's complement:
  - At start, magnitudes are loaded (negative operand -> ~x+1) and sign=op_a[31]^op_b[31] is latched.
  - After CALC, a FIX state runs for 2 cycles when sign=1, reusing the `Adder` to two's-complement-negate the 64-bit result: low word ~lo+1 first, then high word ~hi+carry.
  - If sign=0, FIX takes 2 idle cycles, so latency is constant at 35 edges from the start edge to the done cycle.
  - -2^31 magnitude is 0x80000000 and is handled without overflow.
- When undefined: unsigned only, no FIX state, 33-edge latency. Behaviour is exactly as described above.

Test Plan:
- Reset, then start with op_a=7, op_b=6 -> busy for 33 cycles, single done pulse, product=0x000000000000002A.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> product=0xFFFFFFFE00000001 (carry-out path exercised).
- op_a=0x12345678, op_b=0 -> product=0 after full latency. Then start pulsed every cycle during busy -> ignored, exactly one done.
- Assert rst at CALC iteration 10 of 3*5 -> busy=0, done never pulses, product=0. A fresh 3*5 then yields 0xF.
- Back-to-back: start held high continuously with operands 2*3 then 4*5 -> two done pulses 34 cycles apart, product 6 then 20, product stable between them.
- SIGNED_MUL_EN: -3*5 -> 0xFFFFFFFFFFFFFFF1; 0x80000000*0x80000000 -> 0x4000000000000000; each done 35 edges after start.
